mem_loader: RTL and testbench
=============================

// Module: mem_loader
// PURPOSE
//  Host-side controller for the CPU's external memory ports. Accepts commands on a valid/ready stream
//  and carries them out on the ports: it bursts words into instruction or data memory, reads words back
//  from data memory, and runs the CPU for a fixed number of cycles.
//  Sits between the testbench or host link and the cpu top.
//  Holds cpu_enable low whenever it touches either memory.
// PARAMETERS
//  DATA_W      32  word width of memories and streams
//  LEN_W       16  width of cmd_len (burst length in words / run length in cycles)
//  ADDR_STRIDE 4   byte increment between consecutive words of a burst
//  RD_LAT      1   cycles from ren_ext_2 asserted to rdata_ext_2 valid (1..3)
// PORTS
//  clk          in   1       main clock
//  arst_n       in   1       asynchronous active-low reset
//  cmd_valid    in   1       command offered
//  cmd_ready    out  1       command accepted when valid&ready
//  cmd_op       in   2       0=WR_IMEM 1=WR_DMEM 2=RD_DMEM 3=RUN
//  cmd_addr     in   32      burst start byte address (ignored for RUN)
//  cmd_len      in   LEN_W   words to transfer / cycles to run
//  wr_valid     in   1       write-data word offered
//  wr_ready     out  1       write-data accepted when valid&ready
//  wr_data      in   DATA_W  write-data word
//  rd_valid     out  1       read-back word available
//  rd_ready     in   1       host takes read-back word when valid&ready
//  rd_data      out  DATA_W  read-back word
//  addr_ext / wen_ext / wdata_ext        out 32/1/32  instruction-memory external port
//  ren_ext      out  1       tied 0 (instruction memory is never read back)
//  addr_ext_2 / wen_ext_2 / ren_ext_2 / wdata_ext_2  out 32/1/1/32  data-memory external port
//  rdata_ext_2  in   32      data-memory read data
//  cpu_enable   out  1       drives cpu.enable
//  busy         out  1       high in any state other than IDLE
//  done         out  1       one-cycle pulse when a command completes
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0, except cmd_ready=1. Reset mid-command aborts it; no done pulse.
//  Interface signals that change per cycle (except rd_data) are registered.
//  Command handshake:
//   - cmd_ready=1 only in IDLE.
//   - On acceptance, latch op, addr and len into a byte-address register and a remaining-count register.
//   - len=0 with any op: no memory access and no enable; done pulses on the next cycle; return to IDLE.
//  WR (WR_IMEM / WR_DMEM):
//   - wr_ready=1.
//   - Each wr_valid&wr_ready drives, for exactly one cycle, wen (selected port)=1, addr=current address,
//     wdata=wr_data.
//   - After each write, address += ADDR_STRIDE (mod 2^32, wraps silently) and count -= 1.
//   - wr_valid low inserts idle cycles with wen=0.
//   - On the final word: done pulses with it, then IDLE. Throughput is one word per cycle.
//  RD (RD_DMEM), one word outstanding at a time:
//   - ISSUE: ren_ext_2=1 for one cycle at the current address.
//   - WAIT: RD_LAT cycles, then capture rdata_ext_2 into the holding register.
//   - HOLD: rd_valid=1 and rd_data stable until rd_ready.
//   - On the handshake, address += stride and count -= 1. Loop to ISSUE, or go IDLE with a done pulse
//     after the last word.
//   - rd_ready already high in the capture cycle: that word is taken the following cycle; no bypass.
//  RUN:
//   - cpu_enable=1 for exactly cmd_len consecutive cycles, starting the cycle after acceptance.
//   - All wen/ren are 0 throughout.
//   - done pulses in the first cycle with cpu_enable=0.
//  Invariant: cpu_enable=1 implies wen_ext=wen_ext_2=ren_ext_2=0. wen_ext and wen_ext_2 are never both 1.
//  Ops are issued only from a command; outside the states above every strobe is 0.
// STRUCTURE
//  loader_pkg:
//   - op encodings OP_WR_IMEM..OP_RUN
//   - state localparams IDLE, WR, RD_ISSUE, RD_WAIT, RD_HOLD, RUN, DONE
//   - MEM_ADDR_STRIDE
//  Sub-module loader_rd_buf: single-entry valid/ready holding register for the read-back word.
//  Remainder is one FSM, a byte-address counter and a LEN_W down-counter, built on the shared
//  reg_arstn / reg_arstn_en cells.
// TESTING
//  - WR_IMEM addr=0 len=3 with words A,B,C back-to-back -> wen_ext high 3 consecutive cycles at
//    addr 0,4,8 with data A,B,C; done on the C cycle.
//  - WR_DMEM len=4 with wr_valid gaps -> wen_ext_2 only on handshake cycles; addresses contiguous;
//    cpu_enable stays 0.
//  - Preload dmem[0x10..0x1C]; RD_DMEM addr=0x10 len=4 with rd_ready held low 5 cycles on word 2 ->
//    rd_data stable while stalled; words in order; exactly 4 ren_ext_2 pulses.
//  - RUN len=20 -> cpu_enable high exactly 20 cycles; done on cycle 21; no memory strobes.
//  - len=0 for each op, plus a burst at addr 0xFFFFFFFC len=2 -> len=0 gives done after 1 cycle with no
//    strobes; second burst address is 0x00000000.
//  - arst_n pulsed low mid RD_WAIT and mid RUN -> outputs 0 and cmd_ready=1 immediately; no done pulse;
//    next command executes normally.

Source files
------------

// File: rtl/mem_loader_pkg.sv
// Shared definitions for the memory loader: command opcodes, FSM states and
// the default byte stride between consecutive burst words.
package mem_loader_pkg;

  typedef enum logic [1:0] {
    OP_WR_IMEM = 2'd0,
    OP_WR_DMEM = 2'd1,
    OP_RD_DMEM = 2'd2,
    OP_RUN     = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RD_HOLD  = 3'd4,
    ST_RUN      = 3'd5,
    ST_DONE     = 3'd6
  } state_e;

  localparam int unsigned MEM_ADDR_STRIDE = 4;

endpackage : mem_loader_pkg

// File: rtl/mem_loader_if.sv
// Host command/data streams plus the CPU external memory ports and run
// control, bundled so the loader and its host can be wired with one port.
interface mem_loader_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 16
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [31:0]       cmd_addr;
  logic [LEN_W-1:0]  cmd_len;

  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;

  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;

  logic [31:0]       addr_ext;
  logic              wen_ext;
  logic [DATA_W-1:0] wdata_ext;
  logic              ren_ext;

  logic [31:0]       addr_ext_2;
  logic              wen_ext_2;
  logic              ren_ext_2;
  logic [DATA_W-1:0] wdata_ext_2;
  logic [DATA_W-1:0] rdata_ext_2;

  logic              cpu_enable;
  logic              busy;
  logic              done;

  // Loader side
  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len,
    input  wr_valid, wr_data,
    input  rd_ready,
    input  rdata_ext_2,
    output cmd_ready, wr_ready, rd_valid, rd_data,
    output addr_ext, wen_ext, wdata_ext, ren_ext,
    output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
    output cpu_enable, busy, done
  );

  // Host / memory side
  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len,
    output wr_valid, wr_data,
    output rd_ready,
    output rdata_ext_2,
    input  cmd_ready, wr_ready, rd_valid, rd_data,
    input  addr_ext, wen_ext, wdata_ext, ren_ext,
    input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
    input  cpu_enable, busy, done
  );

endinterface : mem_loader_if

// File: rtl/mem_loader_rd_buf.sv
// Single-entry valid/ready holding register for a data-memory read-back word.
// A load sets valid on the next edge; there is no same-cycle bypass to the host.
module mem_loader_rd_buf #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule : mem_loader_rd_buf

// File: rtl/mem_loader.sv
// Host-side controller for the CPU external memory ports: bursts writes into
// instruction/data memory, reads data memory back, and runs the CPU for N cycles.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned LEN_W       = 16,
  parameter int unsigned ADDR_STRIDE = MEM_ADDR_STRIDE,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic         clk,
  input  logic         arst_n,
  mem_loader_if.slave  bus
);

  state_e            r_state;
  op_e               r_op;
  logic [31:0]       r_addr;
  logic [LEN_W-1:0]  r_count;
  logic [1:0]        r_wait;

  logic              r_cmd_ready;
  logic              r_wr_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_cpu_enable;

  logic [31:0]       r_addr_ext;
  logic              r_wen_ext;
  logic [DATA_W-1:0] r_wdata_ext;

  logic [31:0]       r_addr_ext_2;
  logic              r_wen_ext_2;
  logic              r_ren_ext_2;
  logic [DATA_W-1:0] r_wdata_ext_2;

  logic [31:0]       w_addr_next;
  logic              w_last;
  logic              w_rd_load;
  logic              w_rd_valid;
  logic [DATA_W-1:0] w_rd_data;

  assign w_addr_next = r_addr + 32'(ADDR_STRIDE);
  assign w_last      = (r_count == LEN_W'(1));
  assign w_rd_load   = (r_state == ST_RD_WAIT) && (r_wait == '0);

  mem_loader_rd_buf #(
    .DATA_W (DATA_W)
  ) u_rd_buf (
    .clk     (clk),
    .arst_n  (arst_n),
    .i_load  (w_rd_load),
    .i_data  (bus.rdata_ext_2),
    .i_ready (bus.rd_ready),
    .o_valid (w_rd_valid),
    .o_data  (w_rd_data)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state       <= ST_IDLE;
      r_op          <= OP_WR_IMEM;
      r_addr        <= '0;
      r_count       <= '0;
      r_wait        <= '0;
      r_cmd_ready   <= 1'b1;
      r_wr_ready    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_cpu_enable  <= 1'b0;
      r_addr_ext    <= '0;
      r_wen_ext     <= 1'b0;
      r_wdata_ext   <= '0;
      r_addr_ext_2  <= '0;
      r_wen_ext_2   <= 1'b0;
      r_ren_ext_2   <= 1'b0;
      r_wdata_ext_2 <= '0;
    end else begin
      // Strobes and done are single-cycle unless a state below re-asserts them.
      r_wen_ext   <= 1'b0;
      r_wen_ext_2 <= 1'b0;
      r_ren_ext_2 <= 1'b0;
      r_done      <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            r_op        <= op_e'(bus.cmd_op);
            r_addr      <= bus.cmd_addr;
            r_count     <= bus.cmd_len;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (bus.cmd_len == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              case (op_e'(bus.cmd_op))
                OP_WR_IMEM, OP_WR_DMEM: begin
                  r_state    <= ST_WR;
                  r_wr_ready <= 1'b1;
                end
                OP_RD_DMEM: begin
                  r_state      <= ST_RD_ISSUE;
                  r_ren_ext_2  <= 1'b1;
                  r_addr_ext_2 <= bus.cmd_addr;
                end
                default: begin
                  r_state      <= ST_RUN;
                  r_cpu_enable <= 1'b1;
                end
              endcase
            end
          end
        end

        ST_WR: begin
          if (bus.wr_valid) begin
            if (r_op == OP_WR_IMEM) begin
              r_wen_ext   <= 1'b1;
              r_addr_ext  <= r_addr;
              r_wdata_ext <= bus.wr_data;
            end else begin
              r_wen_ext_2   <= 1'b1;
              r_addr_ext_2  <= r_addr;
              r_wdata_ext_2 <= bus.wr_data;
            end
            r_addr  <= w_addr_next;
            r_count <= r_count - 1'b1;
            // Done rides along with the final write strobe.
            if (w_last) begin
              r_wr_ready <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= ST_DONE;
            end
          end
        end

        ST_RD_ISSUE: begin
          r_state <= ST_RD_WAIT;
          r_wait  <= 2'(RD_LAT - 1);
        end

        ST_RD_WAIT: begin
          if (r_wait == '0) begin
            r_state <= ST_RD_HOLD;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end

        ST_RD_HOLD: begin
          if (w_rd_valid && bus.rd_ready) begin
            r_addr  <= w_addr_next;
            r_count <= r_count - 1'b1;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state      <= ST_RD_ISSUE;
              r_ren_ext_2  <= 1'b1;
              r_addr_ext_2 <= w_addr_next;
            end
          end
        end

        ST_RUN: begin
          if (w_last) begin
            r_cpu_enable <= 1'b0;
            r_done       <= 1'b1;
            r_state      <= ST_DONE;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end

        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end

        default: begin
          r_state      <= ST_IDLE;
          r_busy       <= 1'b0;
          r_cmd_ready  <= 1'b1;
          r_wr_ready   <= 1'b0;
          r_cpu_enable <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.wr_ready    = r_wr_ready;
  assign bus.rd_valid    = w_rd_valid;
  assign bus.rd_data     = w_rd_data;
  assign bus.addr_ext    = r_addr_ext;
  assign bus.wen_ext     = r_wen_ext;
  assign bus.wdata_ext   = r_wdata_ext;
  assign bus.ren_ext     = 1'b0;
  assign bus.addr_ext_2  = r_addr_ext_2;
  assign bus.wen_ext_2   = r_wen_ext_2;
  assign bus.ren_ext_2   = r_ren_ext_2;
  assign bus.wdata_ext_2 = r_wdata_ext_2;
  assign bus.cpu_enable  = r_cpu_enable;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

endmodule : mem_loader

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: write bursts, stalled read-back, run, zero
// length, address wrap and asynchronous reset mid-command.
module tb_mem_loader;
  import mem_loader_pkg::*;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  mem_loader_if #(.DATA_W(32), .LEN_W(16)) bus ();

  mem_loader #(
    .DATA_W      (32),
    .LEN_W       (16),
    .ADDR_STRIDE (4),
    .RD_LAT      (1)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  // Data memory with one-cycle synchronous read
  logic [31:0] dmem [0:63];
  always @(posedge clk) begin
    if (bus.wen_ext_2) dmem[bus.addr_ext_2[7:2]] <= bus.wdata_ext_2;
    if (bus.ren_ext_2) bus.rdata_ext_2 <= dmem[bus.addr_ext_2[7:2]];
  end

  // Strobe / enable / done tallies and invariant violations, sampled per cycle
  int n_wen = 0, n_wen2 = 0, n_ren = 0, n_en = 0, n_done = 0, viol = 0;
  always @(posedge clk) begin
    if (bus.wen_ext)    n_wen++;
    if (bus.wen_ext_2)  n_wen2++;
    if (bus.ren_ext_2)  n_ren++;
    if (bus.cpu_enable) n_en++;
    if (bus.done)       n_done++;
    if ((bus.cpu_enable && (bus.wen_ext || bus.wen_ext_2 || bus.ren_ext_2)) ||
        (bus.wen_ext && bus.wen_ext_2) || bus.ren_ext)
      viol++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic send_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [15:0] len);
    int t;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    t = 0;
    while (!bus.cmd_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_accept", {31'b0, bus.cmd_ready}, 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  logic [31:0] iw [3] = '{32'h0000_000A, 32'h0000_000B, 32'h0000_000C};
  logic [31:0] dw [4] = '{32'hA5A5_0010, 32'h5A5A_0014, 32'hDEAD_0018, 32'hBEEF_001C};
  logic        pat [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int idx, n, t, s_wen, s_wen2, s_ren, s_en, s_done;
    arst_n        = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b1;
    for (int i = 0; i < 64; i++) dmem[i] = '0;

    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    chk("rst_busy",      {31'b0, bus.busy},      32'd0);
    chk("rst_wr_ready",  {31'b0, bus.wr_ready},  32'd0);
    chk("rst_rd_valid",  {31'b0, bus.rd_valid},  32'd0);
    chk("rst_cpu_en",    {31'b0, bus.cpu_enable},32'd0);
    chk("rst_done",      {31'b0, bus.done},      32'd0);
    arst_n = 1'b1;
    @(negedge clk);

    // WR_IMEM addr 0 len 3, back-to-back words
    bus.wr_valid = 1'b1;
    bus.wr_data  = iw[0];
    send_cmd(OP_WR_IMEM, 32'h0, 16'd3);
    chk("wr1_ready",     {31'b0, bus.wr_ready},  32'd1);
    chk("wr1_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
    chk("wr1_busy",      {31'b0, bus.busy},      32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wr1_wen",   {31'b0, bus.wen_ext},   32'd1);
      chk("wr1_wen2",  {31'b0, bus.wen_ext_2}, 32'd0);
      chk("wr1_addr",  bus.addr_ext,           32'(4 * i));
      chk("wr1_data",  bus.wdata_ext,          iw[i]);
      chk("wr1_done",  {31'b0, bus.done},      (i == 2) ? 32'd1 : 32'd0);
      if (i < 2) bus.wr_data = iw[i + 1];
      else       bus.wr_valid = 1'b0;
    end
    @(negedge clk);
    chk("wr1_end_wen",  {31'b0, bus.wen_ext},   32'd0);
    chk("wr1_end_busy", {31'b0, bus.busy},      32'd0);
    chk("wr1_end_rdy",  {31'b0, bus.cmd_ready}, 32'd1);

    // WR_DMEM addr 0x10 len 4 with wr_valid gaps
    s_wen = n_wen;
    send_cmd(OP_WR_DMEM, 32'h10, 16'd4);
    idx = 0;
    for (int k = 0; k < 7; k++) begin
      bus.wr_valid = pat[k];
      if (idx < 4) bus.wr_data = dw[idx];
      @(negedge clk);
      chk("wr2_wen2", {31'b0, bus.wen_ext_2}, {31'b0, pat[k]});
      chk("wr2_cpu",  {31'b0, bus.cpu_enable}, 32'd0);
      if (pat[k]) begin
        chk("wr2_addr", bus.addr_ext_2,  32'h10 + 32'(4 * idx));
        chk("wr2_data", bus.wdata_ext_2, dw[idx]);
        chk("wr2_done", {31'b0, bus.done}, (idx == 3) ? 32'd1 : 32'd0);
        idx++;
      end
    end
    bus.wr_valid = 1'b0;
    @(negedge clk);
    chk("wr2_imem_untouched", 32'(n_wen - s_wen), 32'd0);
    chk("wr2_idle", {31'b0, bus.busy}, 32'd0);

    // RD_DMEM addr 0x10 len 4, second word stalled by rd_ready low
    s_ren = n_ren;
    bus.rd_ready = 1'b1;
    send_cmd(OP_RD_DMEM, 32'h10, 16'd4);
    for (int w = 0; w < 4; w++) begin
      bus.rd_ready = (w != 1);
      t = 0;
      while (!bus.rd_valid && t < 10) begin
        if (bus.ren_ext_2) chk("rd_addr", bus.addr_ext_2, 32'h10 + 32'(4 * w));
        @(negedge clk);
        t++;
      end
      chk("rd_valid_wait", {31'b0, bus.rd_valid}, 32'd1);
      chk("rd_data", bus.rd_data, dw[w]);
      if (w == 1) begin
        repeat (5) begin
          @(negedge clk);
          chk("rd_stall_valid", {31'b0, bus.rd_valid}, 32'd1);
          chk("rd_stall_data",  bus.rd_data, dw[1]);
        end
        bus.rd_ready = 1'b1;
      end
      @(negedge clk);
      chk("rd_taken", {31'b0, bus.rd_valid}, 32'd0);
      chk("rd_done",  {31'b0, bus.done}, (w == 3) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    chk("rd_ren_count", 32'(n_ren - s_ren), 32'd4);
    chk("rd_idle", {31'b0, bus.cmd_ready}, 32'd1);

    // RUN len 20
    s_wen = n_wen; s_wen2 = n_wen2; s_ren = n_ren; s_en = n_en;
    send_cmd(OP_RUN, 32'h0, 16'd20);
    chk("run_first_en", {31'b0, bus.cpu_enable}, 32'd1);
    n = 0;
    for (t = 0; t < 40 && !bus.done; t++) begin
      if (bus.cpu_enable) n++;
      @(negedge clk);
    end
    chk("run_en_cycles", 32'(n), 32'd20);
    chk("run_done",      {31'b0, bus.done},       32'd1);
    chk("run_done_en",   {31'b0, bus.cpu_enable}, 32'd0);
    chk("run_en_tally",  32'(n_en - s_en), 32'd20);
    chk("run_strobes",   32'((n_wen - s_wen) + (n_wen2 - s_wen2) + (n_ren - s_ren)), 32'd0);
    @(negedge clk);

    // len = 0 for every op
    for (int op = 0; op < 4; op++) begin
      s_wen = n_wen; s_wen2 = n_wen2; s_ren = n_ren; s_en = n_en;
      bus.wr_valid = 1'b1;
      send_cmd(2'(op), 32'h40, 16'd0);
      chk("len0_done",     {31'b0, bus.done},      32'd1);
      chk("len0_wr_ready", {31'b0, bus.wr_ready},  32'd0);
      chk("len0_cmd_rdy",  {31'b0, bus.cmd_ready}, 32'd0);
      @(negedge clk);
      chk("len0_done_end", {31'b0, bus.done},      32'd0);
      chk("len0_cmd_back", {31'b0, bus.cmd_ready}, 32'd1);
      chk("len0_strobes",  32'((n_wen - s_wen) + (n_wen2 - s_wen2) + (n_ren - s_ren) + (n_en - s_en)), 32'd0);
      bus.wr_valid = 1'b0;
    end

    // Address wrap at the top of the 32-bit space
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'h1234_5678;
    send_cmd(OP_WR_IMEM, 32'hFFFF_FFFC, 16'd2);
    @(negedge clk);
    chk("wrap_addr0", bus.addr_ext,  32'hFFFF_FFFC);
    chk("wrap_wen0",  {31'b0, bus.wen_ext}, 32'd1);
    bus.wr_data = 32'h8765_4321;
    @(negedge clk);
    chk("wrap_addr1", bus.addr_ext,  32'h0000_0000);
    chk("wrap_data1", bus.wdata_ext, 32'h8765_4321);
    chk("wrap_done",  {31'b0, bus.done}, 32'd1);
    bus.wr_valid = 1'b0;
    @(negedge clk);

    // Reset during RD_WAIT
    send_cmd(OP_RD_DMEM, 32'h10, 16'd2);
    @(negedge clk);
    chk("rstrd_in_wait", {31'b0, bus.busy}, 32'd1);
    s_done = n_done;
    #2 arst_n = 1'b0;
    #1;
    chk("rstrd_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    chk("rstrd_busy",      {31'b0, bus.busy},      32'd0);
    chk("rstrd_rd_valid",  {31'b0, bus.rd_valid},  32'd0);
    chk("rstrd_addr2",     bus.addr_ext_2,         32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstrd_no_done", 32'(n_done - s_done), 32'd0);
    chk("rstrd_rd_idle", {31'b0, bus.rd_valid}, 32'd0);

    // Reset during RUN
    send_cmd(OP_RUN, 32'h0, 16'd10);
    repeat (3) @(negedge clk);
    chk("rstrun_en_before", {31'b0, bus.cpu_enable}, 32'd1);
    s_done = n_done;
    #2 arst_n = 1'b0;
    #1;
    chk("rstrun_en",        {31'b0, bus.cpu_enable}, 32'd0);
    chk("rstrun_cmd_ready", {31'b0, bus.cmd_ready},  32'd1);
    @(negedge clk);
    arst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstrun_no_done", 32'(n_done - s_done), 32'd0);

    // Normal command after reset
    s_en = n_en;
    send_cmd(OP_RUN, 32'h0, 16'd3);
    n = 0;
    for (t = 0; t < 20 && !bus.done; t++) begin
      if (bus.cpu_enable) n++;
      @(negedge clk);
    end
    chk("post_rst_run_cycles", 32'(n), 32'd3);
    chk("post_rst_run_done",   {31'b0, bus.done}, 32'd1);
    chk("post_rst_run_tally",  32'(n_en - s_en), 32'd3);
    @(negedge clk);

    chk("invariants", 32'(viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mem_loader
